// File: rtl/bidir_pad_arbiter.sv
// Round-robin owner arbitration for the shared bidir pad bank.
// Ports: req/req_out/req_oe from core users, cfg_* statics, grant/owner_id/busy status, pad A/OE/CS/SL/IE/PU/PD drives, synced in_data.
module bidir_pad_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int NUM_BIDIR_PADS = 8,
  parameter int TURNAROUND     = 2,
  parameter int MAX_HOLD       = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ*NUM_BIDIR_PADS-1:0] req_out,
  input  logic [NUM_REQ*NUM_BIDIR_PADS-1:0] req_oe,
  input  logic [NUM_BIDIR_PADS-1:0]         cfg_cs,
  input  logic [NUM_BIDIR_PADS-1:0]         cfg_sl,
  input  logic [NUM_BIDIR_PADS-1:0]         cfg_pu,
  input  logic [NUM_BIDIR_PADS-1:0]         cfg_pd,
  output logic [NUM_REQ-1:0]                grant,
  output logic [2:0]                        owner_id,
  output logic                              busy,
  input  logic [NUM_BIDIR_PADS-1:0]         bidir_in,
  output logic [NUM_BIDIR_PADS-1:0]         in_data,
  output logic [NUM_BIDIR_PADS-1:0]         bidir_out,
  output logic [NUM_BIDIR_PADS-1:0]         bidir_oe,
  output logic [NUM_BIDIR_PADS-1:0]         bidir_cs,
  output logic [NUM_BIDIR_PADS-1:0]         bidir_sl,
  output logic [NUM_BIDIR_PADS-1:0]         bidir_ie,
  output logic [NUM_BIDIR_PADS-1:0]         bidir_pu,
  output logic [NUM_BIDIR_PADS-1:0]         bidir_pd
);

  localparam int W = NUM_BIDIR_PADS;
  localparam logic [3:0] TA   = 4'(TURNAROUND);
  localparam logic [7:0] HMAX = 8'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE,
    TURN,
    OWN
  } state_t;

  state_t state, state_n;

  logic [2:0]   ptr, ptr_n;
  logic [2:0]   owner_n;
  logic [2:0]   base, win;
  logic [3:0]   tcnt, tcnt_n;
  logic [7:0]   hold, hold_n;
  logic [7:0]   req8, own_oh, others;
  logic         own, drop, preempt;
  logic [W-1:0] sel_out, sel_oe;
  logic [W-1:0] sync1, sync2;

  // First set bit scanning b+1, b+2, ... modulo NUM_REQ.
  function automatic logic [2:0] pick(
    input logic [7:0] r,
    input logic [2:0] b
  );
    logic [2:0] w;
    logic [2:0] idx;
    logic       hit;
    w   = b;
    hit = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = 3'((int'(b) + i) % NUM_REQ);
      if (!hit && r[idx]) begin
        w   = idx;
        hit = 1'b1;
      end
    end
    return w;
  endfunction

  assign req8    = 8'(req);
  assign own_oh  = 8'd1 << owner_id;
  assign others  = req8 & ~own_oh;
  assign drop    = !req8[owner_id];
  assign preempt = (hold == HMAX) && (|others);

  // On an OWN exit the scan restarts after the outgoing owner.
  assign base = (state == OWN) ? owner_id : ptr;
  assign win  = pick(req8, base);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner_id;
    tcnt_n  = tcnt;
    hold_n  = hold;
    unique case (state)
      IDLE: begin
        if (|req8) begin
          owner_n = win;
          tcnt_n  = TA;
          state_n = TURN;
        end
      end
      TURN: begin
        if (drop) begin
          tcnt_n  = '0;
          state_n = IDLE;
        end else if (tcnt == 4'd1) begin
          tcnt_n  = '0;
          hold_n  = '0;
          state_n = OWN;
        end else begin
          tcnt_n = tcnt - 4'd1;
        end
      end
      OWN: begin
        if (drop || preempt) begin
          ptr_n  = owner_id;
          hold_n = '0;
          if (|others) begin
            owner_n = win;
            tcnt_n  = TA;
            state_n = TURN;
          end else begin
            state_n = IDLE;
          end
        end else if (hold != HMAX) begin
          hold_n = hold + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 3'(NUM_REQ - 1);
      owner_id <= '0;
      tcnt     <= '0;
      hold     <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      owner_id <= owner_n;
      tcnt     <= tcnt_n;
      hold     <= hold_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bidir_in;
      sync2 <= sync1;
    end
  end

  always_comb begin
    sel_out = '0;
    sel_oe  = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (owner_id == 3'(r)) begin
        sel_out = req_out[r*W +: W];
        sel_oe  = req_oe[r*W +: W];
      end
    end
  end

  // Drive is gated by registered state only, so req changes never glitch OE.
  assign own       = (state == OWN);
  assign grant     = own ? own_oh[NUM_REQ-1:0] : '0;
  assign busy      = (state != IDLE);
  assign bidir_out = own ? sel_out : '0;
  assign bidir_oe  = own ? sel_oe : '0;
  assign bidir_cs  = cfg_cs;
  assign bidir_sl  = cfg_sl;
  assign bidir_ie  = '1;
  assign bidir_pu  = cfg_pu;
  assign bidir_pd  = cfg_pd & ~cfg_pu;
  assign in_data   = sync2;

endmodule

// File: tb/tb_bidir_pad_arbiter.sv
// Bench for bidir_pad_arbiter: directed literal checks plus random traffic.
// A cycle-level owner/turnaround model predicts every output each cycle.
module tb_bidir_pad_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TA = 2;
  localparam int MH = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_out, req_oe;
  logic [W-1:0]   cfg_cs, cfg_sl, cfg_pu, cfg_pd;
  logic [N-1:0]   grant;
  logic [2:0]     owner_id;
  logic           busy;
  logic [W-1:0]   bidir_in, in_data;
  logic [W-1:0]   bidir_out, bidir_oe, bidir_cs, bidir_sl;
  logic [W-1:0]   bidir_ie, bidir_pu, bidir_pd;

  bidir_pad_arbiter #(
    .NUM_REQ(N), .NUM_BIDIR_PADS(W),
    .TURNAROUND(TA), .MAX_HOLD(MH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .req_out(req_out), .req_oe(req_oe),
    .cfg_cs(cfg_cs), .cfg_sl(cfg_sl),
    .cfg_pu(cfg_pu), .cfg_pd(cfg_pd),
    .grant(grant), .owner_id(owner_id), .busy(busy),
    .bidir_in(bidir_in), .in_data(in_data),
    .bidir_out(bidir_out), .bidir_oe(bidir_oe),
    .bidir_cs(bidir_cs), .bidir_sl(bidir_sl),
    .bidir_ie(bidir_ie), .bidir_pu(bidir_pu),
    .bidir_pd(bidir_pd)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  // model: owner (-1 none), high-Z cycles left, granted cycles done
  int m_owner, m_turn, m_held, m_ptr;
  logic [W-1:0] m_prev_in, m_exp_in;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t",
                  nm, act, exp, $time);
  endtask

  function automatic int scan(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner   = -1;
    m_turn    = 0;
    m_held    = 0;
    m_ptr     = N - 1;
    m_prev_in = '0;
    m_exp_in  = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] r, oth;
    int done;
    r = req;
    if (m_owner < 0) begin
      if (r != 0) begin
        m_owner = scan(r, m_ptr);
        m_turn  = TA;
      end
    end else if (m_turn > 0) begin
      if (!r[m_owner]) m_owner = -1;
      else m_turn--;
      m_held = 0;
    end else begin
      oth = r;
      oth[m_owner] = 1'b0;
      done = m_held + 1;
      if (!r[m_owner] || (done >= MH && oth != 0)) begin
        m_ptr  = m_owner;
        m_held = 0;
        if (oth != 0) begin
          m_owner = scan(oth, m_ptr);
          m_turn  = TA;
        end else begin
          m_owner = -1;
        end
      end else begin
        m_held = done;
      end
    end
    m_exp_in  = m_prev_in;
    m_prev_in = bidir_in;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [N-1:0] e_g;
  logic [W-1:0] e_o, e_e;

  always @(negedge clk) begin
    if (chk_en) begin
      e_g = '0;
      e_o = '0;
      e_e = '0;
      if (m_owner >= 0 && m_turn == 0) begin
        e_g[m_owner] = 1'b1;
        e_o = req_out[m_owner*W +: W];
        e_e = req_oe[m_owner*W +: W];
      end
      chk("grant", 32'(grant), 32'(e_g));
      chk("busy", 32'(busy), 32'(m_owner >= 0));
      chk("bidir_out", 32'(bidir_out), 32'(e_o));
      chk("bidir_oe", 32'(bidir_oe), 32'(e_e));
      chk("bidir_ie", 32'(bidir_ie), 32'hFF);
      chk("bidir_cs", 32'(bidir_cs), 32'(cfg_cs));
      chk("bidir_sl", 32'(bidir_sl), 32'(cfg_sl));
      chk("bidir_pu", 32'(bidir_pu), 32'(cfg_pu));
      chk("bidir_pd", 32'(bidir_pd), 32'(cfg_pd & ~cfg_pu));
      chk("in_data", 32'(in_data), 32'(m_exp_in));
      if (m_owner >= 0)
        chk("owner_id", 32'(owner_id), 32'(m_owner));
    end
  end

  logic [N-1:0] oh;

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    req_out  = '0;
    req_oe   = '0;
    cfg_cs   = 8'h5A;
    cfg_sl   = 8'hC3;
    cfg_pu   = '0;
    cfg_pd   = '0;
    bidir_in = '0;
    model_reset();
    chk_en = 1'b1;
    tick();
    tick();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_owner", 32'(owner_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_oe", 32'(bidir_oe), 32'h0);
    chk("rst_out", 32'(bidir_out), 32'h0);
    chk("rst_ie", 32'(bidir_ie), 32'hFF);
    chk("rst_cs", 32'(bidir_cs), 32'h5A);
    rst_n = 1'b1;
    tick();

    // first grant latency and owner data path
    req = 4'b0001;
    req_out[7:0] = 8'hA5;
    req_oe[7:0]  = 8'hFF;
    tick();
    chk("lat_t1", 32'(grant), 32'h0);
    tick();
    chk("lat_t2", 32'(grant), 32'h0);
    tick();
    chk("lat_t3", 32'(grant), 32'h1);
    chk("lat_out", 32'(bidir_out), 32'hA5);
    chk("lat_oe", 32'(bidir_oe), 32'hFF);

    cfg_pu = 8'h01;
    cfg_pd = 8'h01;
    #1;
    chk("pull_pu", 32'(bidir_pu), 32'h01);
    chk("pull_pd", 32'(bidir_pd), 32'h00);

    bidir_in = 8'h3C;
    tick();
    chk("sync_1", 32'(in_data), 32'h00);
    tick();
    chk("sync_2", 32'(in_data), 32'h3C);

    // owner 2 drops with req[0] waiting
    reset_dut();
    req = 4'b0100;
    tick(); tick(); tick();
    chk("drop_own", 32'(grant), 32'h4);
    req = 4'b0101;
    tick(); tick();
    req = 4'b0001;
    #1;
    chk("drop_hold", 32'(grant), 32'h4);
    tick();
    chk("drop_z1", 32'(grant), 32'h0);
    tick();
    chk("drop_z2", 32'(grant), 32'h0);
    tick();
    chk("drop_next", 32'(grant), 32'h1);

    // one-cycle pulse aborts during turnaround
    reset_dut();
    req = 4'b0010;
    tick();
    req = 4'b0000;
    #1;
    chk("abort_busy1", 32'(busy), 32'h1);
    chk("abort_owner", 32'(owner_id), 32'h1);
    tick();
    chk("abort_busy0", 32'(busy), 32'h0);
    chk("abort_grant", 32'(grant), 32'h0);
    tick();

    // full contention: ptr still 3, so 0 first then rotate
    req    = 4'b1111;
    req_oe = '1;
    tick(); tick(); tick();
    for (int k = 0; k <= 4; k++) begin
      oh = 4'b0001 << (k % 4);
      for (int c = 0; c < 18; c++) begin
        if (c == 0 || c == 15)
          chk("rot_grant", 32'(grant), 32'(oh));
        if (c >= 16) begin
          chk("rot_gap_g", 32'(grant), 32'h0);
          chk("rot_gap_oe", 32'(bidir_oe), 32'h0);
        end
        if (k == 4) break;
        tick();
      end
    end

    // asynchronous reset mid-ownership
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_grant", 32'(grant), 32'h0);
    chk("arst_oe", 32'(bidir_oe), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("arst_first", 32'(grant), 32'h1);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) == 0) req[i] = ~req[i];
      if ($urandom_range(0, 199) == 0) req = '0;
      req_out  = $urandom;
      req_oe   = $urandom;
      bidir_in = W'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        cfg_cs = W'($urandom);
        cfg_sl = W'($urandom);
        cfg_pu = W'($urandom);
        cfg_pd = W'($urandom);
      end
      if ($urandom_range(0, 999) == 0) begin
        #2;
        reset_dut();
      end
      tick();
    end

    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bidir_pad_arbiter.md
Name: bidir_pad_arbiter

Overview:
- Shares the bidirectional pad bank between NUM_REQ core requesters. Round-robin grant, with a forced high-Z turnaround between owners and a hold-time limit that lets waiting requesters preempt the owner.
- Drives every bidir pad control input (A/OE/CS/SL/IE/PU/PD) from core-side logic.
- Returns pad input data to the core through a 2-flop synchronizer.
- Sits in chip_core between the user blocks and the bidir pad instances.

Parameters:
- NUM_REQ, 4, number of requesters; range 2..8.
- NUM_BIDIR_PADS, 8, width of the pad bank.
- TURNAROUND, 2, high-Z cycles before any new grant; range 1..15.
- MAX_HOLD, 16, granted cycles after which a waiting requester preempts the owner; range 2..255.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester level request.
- req_out  in  NUM_REQ*NUM_BIDIR_PADS  per-requester drive data; slice r = bits [r*W +: W].
- req_oe  in  NUM_REQ*NUM_BIDIR_PADS  per-requester output enables; same slicing.
- cfg_cs  in  NUM_BIDIR_PADS  static Schmitt select; passed through.
- cfg_sl  in  NUM_BIDIR_PADS  static slew select; passed through.
- cfg_pu  in  NUM_BIDIR_PADS  static pull-up select.
- cfg_pd  in  NUM_BIDIR_PADS  static pull-down select.
- grant  out  NUM_REQ  one-hot or zero.
- owner_id  out  3  index of current or pending owner.
- busy  out  1  state != IDLE.
- bidir_in  in  NUM_BIDIR_PADS  pad Y outputs.
- in_data  out  NUM_BIDIR_PADS  synchronized bidir_in, broadcast to all requesters.
- bidir_out  out  NUM_BIDIR_PADS  to pad A.
- bidir_oe  out  NUM_BIDIR_PADS  to pad OE.
- bidir_cs  out  NUM_BIDIR_PADS  to pad CS.
- bidir_sl  out  NUM_BIDIR_PADS  to pad SL.
- bidir_ie  out  NUM_BIDIR_PADS  to pad IE.
- bidir_pu  out  NUM_BIDIR_PADS  to pad PU.
- bidir_pd  out  NUM_BIDIR_PADS  to pad PD.

Behaviour:
- Reset values:
  - state=IDLE, grant=0, owner_id=0, busy=0.
  - RR pointer ptr=NUM_REQ-1, so req[0] wins first.
  - Turnaround and hold counters = 0.
  - Sync flops = 0.
- Outputs while in reset: bidir_oe=0, bidir_out=0, bidir_ie=all 1; cs/sl/pu/pd follow cfg_*.
- Pull conflict: if cfg_pu[i] and cfg_pd[i] are both 1, bidir_pd[i] is forced to 0 (pull-up wins).
- Arbitration: winner = first set req bit scanning ptr+1, ptr+2, ... mod NUM_REQ.
- IDLE: grant=0, pads high-Z. If any req, latch winner into owner_id, load tcnt=TURNAROUND, go to TURN.
- TURN:
  - grant=0, pads high-Z.
  - tcnt decrements each cycle; at tcnt==1, go to OWN.
  - Timing: req seen at cycle T gives grant high from T+TURNAROUND+1.
  - If req[owner_id] drops during TURN, return to IDLE with ptr unchanged.
  - Reset mid-TURN returns to reset values.
- OWN:
  - grant[owner_id]=1.
  - bidir_out and bidir_oe come combinationally from that owner's slices of req_out and req_oe (no added latency).
  - hold counter increments, saturating at MAX_HOLD-1.
- Leaving OWN:
  - Exit when req[owner_id]=0, or when hold==MAX_HOLD-1 and another req bit is set (preemption).
  - On exit: ptr=owner_id; grant and bidir_oe drop the next cycle. Owner-slice muxing is gated by registered state, so there is no glitch drive.
  - If another req is pending on exit, pick the next winner and go straight to TURN. Otherwise go to IDLE.
  - A sole requester keeps ownership indefinitely; hold saturates and nothing is preempted.
  - A preempted requester that holds req high is re-served after the other pending requesters.
- Simultaneous events: an owner drop coinciding with the preemption point counts as a single exit, not two.
- bidir_ie: 1 on every pad at all times; input is always enabled.
- in_data: 2-flop sync of bidir_in, latency 2 cycles, independent of arbitration state.
- No combinational path from req to grant.

Test Plan:
- Reset then req=4'b0001 at T → grant=0 for T+1..T+2, grant=4'b0001 at T+3. With req_out slice0=8'hA5 and req_oe slice0=8'hFF, bidir_out=8'hA5 and bidir_oe=8'hFF at T+3.
- req=4'b1111 held continuously, MAX_HOLD=16 → owners rotate 0,1,2,3,0; each grant lasts 16 cycles; exactly 2 cycles with grant=0 and bidir_oe=0 between owners.
- Owner 2 drops req while req[0]=1 → grant drops next cycle, 2 high-Z cycles, then grant=4'b0001 (ptr=2 gives order 3,0).
- req[1] pulses for 1 cycle during TURN → busy falls back to 0, grant never asserts, ptr stays unchanged.
- rst_n asserted asynchronously mid-OWN with bidir_oe=8'hFF → bidir_oe=0 and grant=0 immediately without a clock edge; after release, req[0] wins first.
- bidir_in toggles 8'h3C → in_data=8'h3C two cycles later. cfg_pu=cfg_pd=8'h01 → bidir_pu=8'h01, bidir_pd=8'h00.
